// File: rtl/mimo_det_pkg.sv
// Shared constants and FSM state type for the spatial-modulation detector.
// Latency: n/a (types and parameters only).
// Backpressure: n/a.
package mimo_det_pkg;

  localparam int N      = 16;
  localparam int NUM_CW = 16;
  localparam int SPC    = 8;
  localparam int MET_W  = 2*N + 5;
  localparam int TERM_W = 2*N + 3;
  localparam int CNT_W  = $clog2(SPC);
  localparam int CW_W   = $clog2(NUM_CW);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_Y  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DRAIN   = 2'd3
  } det_state_t;

endpackage

// File: rtl/cplx_dist_sq.sv
// Complex squared distance |y - h|^2 with valid/last passthrough.
// Latency: 2 registered stages (operand capture, difference); square is combinational off stage 2.
// Backpressure: none; flush drops in-flight samples.
module cplx_dist_sq
  import mimo_det_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                vld,
  input  logic                last,
  input  logic signed [N-1:0] y_r,
  input  logic signed [N-1:0] y_i,
  input  logic signed [N-1:0] h_r,
  input  logic signed [N-1:0] h_i,
  output logic                term_vld,
  output logic                term_last,
  output logic [TERM_W-1:0]   term
);

  logic                s1_vld, s1_last;
  logic signed [N-1:0] s1_y_r, s1_y_i, s1_h_r, s1_h_i;
  logic [N:0]          d_r, d_i;
  logic [2*N+1:0]      d_r_x, d_i_x, sq_r, sq_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s1_y_r    <= '0;
      s1_y_i    <= '0;
      s1_h_r    <= '0;
      s1_h_i    <= '0;
      term_vld  <= 1'b0;
      term_last <= 1'b0;
      d_r       <= '0;
      d_i       <= '0;
    end else begin
      s1_vld    <= vld & ~flush;
      s1_last   <= last;
      s1_y_r    <= y_r;
      s1_y_i    <= y_i;
      s1_h_r    <= h_r;
      s1_h_i    <= h_i;
      term_vld  <= s1_vld & ~flush;
      term_last <= s1_last;
      d_r       <= {s1_y_r[N-1], s1_y_r} - {s1_h_r[N-1], s1_h_r};
      d_i       <= {s1_y_i[N-1], s1_y_i} - {s1_h_i[N-1], s1_h_i};
    end
  end

  // Sign-extend to the product width; the low bits of the unsigned product equal the exact square.
  assign d_r_x = {{(N+1){d_r[N]}}, d_r};
  assign d_i_x = {{(N+1){d_i[N]}}, d_i};
  assign sq_r  = d_r_x * d_r_x;
  assign sq_i  = d_i_x * d_i_x;
  assign term  = {1'b0, sq_r} + {1'b0, sq_i};

endmodule

// File: rtl/ml_metric_selector.sv
// ML decision: accumulates ||Y - Hq||^2 per codeword and reports the argmin index.
// Latency: metric_valid / det_valid 3 edges after the accepting edge of a codeword's last sample.
// Backpressure: none; y_valid/hq_valid may gap freely, start aborts and restarts a frame.
module ml_metric_selector
  import mimo_det_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                y_valid,
  input  logic signed [N-1:0] y_r,
  input  logic signed [N-1:0] y_i,
  input  logic                hq_valid,
  input  logic signed [N-1:0] hq_r,
  input  logic signed [N-1:0] hq_i,
  output logic                busy,
  output logic                metric_valid,
  output logic [3:0]          metric_q,
  output logic [MET_W-1:0]    metric_out,
  output logic                det_valid,
  output logic [3:0]          q_hat,
  output logic [MET_W-1:0]    min_metric
);

  det_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [CW_W-1:0]     cw;
  logic [CW_W-1:0]     q_cls;
  logic signed [N-1:0] y_mem_r [SPC];
  logic signed [N-1:0] y_mem_i [SPC];
  logic [MET_W-1:0]    acc;
  logic                acc_fresh;
  logic                acc_close;
  logic [MET_W-1:0]    best_met;
  logic [CW_W-1:0]     best_q;

  logic                feed_vld;
  logic                feed_last;
  logic                term_vld, term_last;
  logic [TERM_W-1:0]   term;
  logic                cmp_lt;
  logic [MET_W-1:0]    nxt_best_met;
  logic [CW_W-1:0]     nxt_best_q;

  assign busy      = (state != ST_IDLE);
  assign feed_vld  = (state == ST_COLLECT) & hq_valid & ~start;
  assign feed_last = (cnt == CNT_W'(SPC-1));

  cplx_dist_sq u_dist (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .vld       (feed_vld),
    .last      (feed_last),
    .y_r       (y_mem_r[cnt]),
    .y_i       (y_mem_i[cnt]),
    .h_r       (hq_r),
    .h_i       (hq_i),
    .term_vld  (term_vld),
    .term_last (term_last),
    .term      (term)
  );

  // Strict less-than keeps the lower index on ties.
  always_comb begin
    cmp_lt       = (acc < best_met);
    nxt_best_met = cmp_lt ? acc   : best_met;
    nxt_best_q   = cmp_lt ? q_cls : best_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cw           <= '0;
      q_cls        <= '0;
      acc          <= '0;
      acc_fresh    <= 1'b1;
      acc_close    <= 1'b0;
      best_met     <= '1;
      best_q       <= '0;
      metric_valid <= 1'b0;
      metric_q     <= '0;
      metric_out   <= '0;
      det_valid    <= 1'b0;
      q_hat        <= '0;
      min_metric   <= '0;
      for (int i = 0; i < SPC; i++) begin
        y_mem_r[i] <= '0;
        y_mem_i[i] <= '0;
      end
    end else begin
      metric_valid <= 1'b0;
      det_valid    <= 1'b0;
      if (start) begin
        state     <= ST_LOAD_Y;
        cnt       <= '0;
        cw        <= '0;
        q_cls     <= '0;
        acc       <= '0;
        acc_fresh <= 1'b1;
        acc_close <= 1'b0;
        best_met  <= '1;
        best_q    <= '0;
      end else begin
        case (state)
          ST_LOAD_Y: begin
            if (y_valid) begin
              y_mem_r[cnt] <= y_r;
              y_mem_i[cnt] <= y_i;
              cnt          <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(SPC-1))
                state <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (hq_valid) begin
              cnt <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(SPC-1)) begin
                cw <= cw + CW_W'(1);
                if (cw == CW_W'(NUM_CW-1))
                  state <= ST_DRAIN;
              end
            end
          end
          default: ;
        endcase

        // A new codeword restarts the sum while the previous one is being closed.
        if (term_vld) begin
          acc       <= acc_fresh ? {{(MET_W-TERM_W){1'b0}}, term}
                                 : acc + {{(MET_W-TERM_W){1'b0}}, term};
          acc_fresh <= term_last;
        end
        acc_close <= term_vld & term_last;

        if (acc_close) begin
          metric_out   <= acc;
          metric_q     <= q_cls;
          metric_valid <= 1'b1;
          best_met     <= nxt_best_met;
          best_q       <= nxt_best_q;
          q_cls        <= q_cls + CW_W'(1);
          if (q_cls == CW_W'(NUM_CW-1)) begin
            det_valid  <= 1'b1;
            q_hat      <= nxt_best_q;
            min_metric <= nxt_best_met;
            state      <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ml_metric_selector.sv
// Directed bench for ml_metric_selector with a per-frame distance model and literal pins.
module tb_ml_metric_selector;
  import mimo_det_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             y_valid = 1'b0;
  logic             hq_valid = 1'b0;
  logic [N-1:0]     y_r = '0, y_i = '0, hq_r = '0, hq_i = '0;
  logic             busy, metric_valid, det_valid;
  logic [3:0]       metric_q, q_hat;
  logic [MET_W-1:0] metric_out, min_metric;

  ml_metric_selector dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y_valid(y_valid), .y_r(y_r), .y_i(y_i),
    .hq_valid(hq_valid), .hq_r(hq_r), .hq_i(hq_i),
    .busy(busy), .metric_valid(metric_valid), .metric_q(metric_q),
    .metric_out(metric_out), .det_valid(det_valid), .q_hat(q_hat),
    .min_metric(min_metric)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     ty_r [SPC], ty_i [SPC];
  int     th_r [NUM_CW][SPC], th_i [NUM_CW][SPC];
  longint exp_met [NUM_CW];
  int     exp_q;
  longint exp_min;

  int     vectors = 0, errors = 0;
  int     mon_q = 0, det_total = 0, det_cyc = 0, last_acc = 0;
  bit     det_flag = 1'b0;
  int     got_q = 0;
  longint got_min = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Reference: plain sum of squared differences and first-minimum search.
  function automatic void model();
    longint dr, di, s;
    for (int q = 0; q < NUM_CW; q++) begin
      s = 0;
      for (int i = 0; i < SPC; i++) begin
        dr = longint'(ty_r[i]) - longint'(th_r[q][i]);
        di = longint'(ty_i[i]) - longint'(th_i[q][i]);
        s += dr*dr + di*di;
      end
      exp_met[q] = s;
    end
    exp_q = 0;
    exp_min = exp_met[0];
    for (int q = 1; q < NUM_CW; q++)
      if (exp_met[q] < exp_min) begin
        exp_min = exp_met[q];
        exp_q = q;
      end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (start) begin
        mon_q = 0;
        det_flag = 1'b0;
      end
      if (metric_valid) begin
        if (mon_q < NUM_CW) begin
          chk("metric_q", longint'(metric_q), longint'(mon_q));
          chk("metric_out", longint'(metric_out), exp_met[mon_q]);
        end else
          chk("extra_metric_pulse", longint'(mon_q), longint'(NUM_CW-1));
        mon_q++;
      end
      if (det_valid) begin
        chk("det_with_last_metric", longint'(metric_valid), 1);
        chk("busy_at_det", longint'(busy), 0);
        chk("q_hat", longint'(q_hat), longint'(exp_q));
        chk("min_metric", longint'(min_metric), exp_min);
        got_q = int'(q_hat);
        got_min = longint'(min_metric);
        det_cyc = cyc;
        det_total++;
        det_flag = 1'b1;
      end
    end
  end

  function automatic int rnd16();
    return int'($urandom_range(65535, 0)) - 32768;
  endfunction

  task automatic set_y(input int r, input int i);
    for (int k = 0; k < SPC; k++) begin ty_r[k] = r; ty_i[k] = i; end
  endtask

  task automatic set_h(input int q, input int r, input int i);
    for (int k = 0; k < SPC; k++) begin th_r[q][k] = r; th_i[q][k] = i; end
  endtask

  task automatic set_h_all(input int r, input int i);
    for (int q = 0; q < NUM_CW; q++) set_h(q, r, i);
  endtask

  task automatic set_random();
    for (int k = 0; k < SPC; k++) begin ty_r[k] = rnd16(); ty_i[k] = rnd16(); end
    for (int q = 0; q < NUM_CW; q++)
      for (int k = 0; k < SPC; k++) begin th_r[q][k] = rnd16(); th_i[q][k] = rnd16(); end
  endtask

  task automatic gap(input int gmax);
    if (gmax > 0)
      repeat ($urandom_range(gmax, 0)) begin @(posedge clk); #1; end
  endtask

  task automatic start_frame();
    model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Noise drives the strobe that the current state must ignore.
  task automatic put_y(input int gmax, input bit noise);
    for (int k = 0; k < SPC; k++) begin
      gap(gmax);
      y_valid = 1'b1;
      y_r = N'(ty_r[k]);
      y_i = N'(ty_i[k]);
      if (noise) begin
        hq_valid = 1'b1;
        hq_r = N'($urandom);
        hq_i = N'($urandom);
      end
      @(posedge clk); #1;
      y_valid = 1'b0;
      hq_valid = 1'b0;
    end
  endtask

  task automatic put_hq(input int gmax, input bit noise, input int n);
    for (int k = 0; k < n; k++) begin
      gap(gmax);
      hq_valid = 1'b1;
      hq_r = N'(th_r[k / SPC][k % SPC]);
      hq_i = N'(th_i[k / SPC][k % SPC]);
      if (noise) begin
        y_valid = 1'b1;
        y_r = N'($urandom);
        y_i = N'($urandom);
      end
      @(posedge clk); #1;
      last_acc = cyc;
      hq_valid = 1'b0;
      y_valid = 1'b0;
    end
  endtask

  task automatic wait_det(input string nm);
    int t = 0;
    while (!det_flag && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    chk(nm, longint'(det_flag), 1);
    if (det_flag) begin
      chk("det_latency", longint'(det_cyc - last_acc), 3);
      chk("metric_pulse_count", longint'(mon_q), longint'(NUM_CW));
    end
  endtask

  task automatic run(input string nm, input int gmax, input bit noise);
    start_frame();
    put_y(gmax, noise);
    put_hq(gmax, noise, NUM_CW*SPC);
    wait_det(nm);
  endtask

  int     sv_q, dt;
  longint sv_min;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_metric_valid", longint'(metric_valid), 0);
    chk("rst_det_valid", longint'(det_valid), 0);
    chk("rst_metric_q", longint'(metric_q), 0);
    chk("rst_metric_out", longint'(metric_out), 0);
    chk("rst_q_hat", longint'(q_hat), 0);
    chk("rst_min_metric", longint'(min_metric), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_y(0, 0);
    set_h_all(256, 0);
    set_h(5, 0, 0);
    run("zero_target_det", 0, 1'b0);
    chk("zero_qhat_lit", longint'(got_q), 5);
    chk("zero_min_lit", got_min, 0);
    chk("zero_model_other", exp_met[0], 524288);

    set_h_all(128, 128);
    run("ties_det", 0, 1'b0);
    chk("ties_qhat_lit", longint'(got_q), 0);
    chk("ties_min_lit", got_min, 262144);

    set_y(32767, 32767);
    set_h_all(-32768, -32768);
    run("extreme_det", 0, 1'b0);
    chk("extreme_qhat_lit", longint'(got_q), 0);
    chk("extreme_min_lit", got_min, 64'd68717379600);
    set_h(15, 32767, 32767);
    run("extreme15_det", 0, 1'b0);
    chk("extreme15_qhat_lit", longint'(got_q), 15);
    chk("extreme15_min_lit", got_min, 0);

    set_random();
    run("rand_b2b_det", 0, 1'b0);
    sv_q = got_q;
    sv_min = got_min;
    run("rand_gap_det", 3, 1'b1);
    chk("gap_same_qhat", longint'(got_q), longint'(sv_q));
    chk("gap_same_min", got_min, sv_min);

    set_random();
    start_frame();
    put_y(0, 1'b0);
    put_hq(1, 1'b0, 7*SPC + 5);
    dt = det_total;
    set_random();
    start_frame();
    chk("abort_busy", longint'(busy), 1);
    put_y(0, 1'b0);
    put_hq(0, 1'b0, NUM_CW*SPC);
    wait_det("abort_fresh_det");
    chk("abort_det_count", longint'(det_total), longint'(dt + 1));

    set_random();
    start_frame();
    put_y(0, 1'b0);
    put_hq(0, 1'b0, 40);
    rst_n = 1'b0;
    #2;
    chk("arst_busy", longint'(busy), 0);
    chk("arst_metric_valid", longint'(metric_valid), 0);
    chk("arst_det_valid", longint'(det_valid), 0);
    chk("arst_metric_q", longint'(metric_q), 0);
    chk("arst_metric_out", longint'(metric_out), 0);
    chk("arst_q_hat", longint'(q_hat), 0);
    chk("arst_min_metric", longint'(min_metric), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_random();
    run("post_reset_det", 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
